// File: rtl/hrm_pkg.sv
// Shared constants and helpers for the IO box FIFO bank.
package hrm_pkg;

    localparam int HRM_DW      = 8;
    localparam int HRM_LGDEPTH = 5;
    localparam int HRM_NCH     = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hrm_fifo_ch.sv
// One circular-buffer FIFO channel with first-word-fall-through head and a
// combinational dump-read port addressed relative to the oldest entry.
module hrm_fifo_ch
    import hrm_pkg::*;
#(
    parameter int DW      = HRM_DW,
    parameter int LGDEPTH = HRM_LGDEPTH
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic [DW-1:0]      i_data,
    input  logic               i_rd,
    input  logic               i_clr,
    output logic [DW-1:0]      o_data,
    output logic               o_empty_n,
    output logic               o_full,
    output logic               o_err,
    output logic [LGDEPTH:0]   o_fill,
    input  logic [LGDEPTH-1:0] i_dmp_pos,
    output logic [DW-1:0]      o_dmp_data,
    output logic               o_dmp_valid
);

    localparam int DEPTH = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0] FULL_CNT = (LGDEPTH + 1)'(DEPTH);

    logic [DW-1:0]      mem [DEPTH];
    logic [LGDEPTH-1:0] wrptr_reg, wrptr_next;
    logic [LGDEPTH-1:0] rdptr_reg, rdptr_next;
    logic [LGDEPTH:0]   fill_reg, fill_next;
    logic               err_reg, err_next;
    logic               is_empty, is_full, rd_ok, wr_ok;

    assign is_empty = (fill_reg == '0);
    assign is_full  = (fill_reg == FULL_CNT);
    assign rd_ok    = i_rd && !is_empty;
    // A full channel still accepts a push when a pop frees the slot this cycle.
    assign wr_ok    = i_wr && (!is_full || rd_ok);

    always_comb begin
        wrptr_next = wrptr_reg;
        rdptr_next = rdptr_reg;
        fill_next  = fill_reg;
        err_next   = err_reg;
        if (i_clr) begin
            wrptr_next = '0;
            rdptr_next = '0;
            fill_next  = '0;
            err_next   = 1'b0;
        end else begin
            if (wr_ok) wrptr_next = wrptr_reg + 1'b1;
            if (rd_ok) rdptr_next = rdptr_reg + 1'b1;
            if (wr_ok && !rd_ok) fill_next = fill_reg + 1'b1;
            else if (rd_ok && !wr_ok) fill_next = fill_reg - 1'b1;
            if ((i_rd && is_empty) || (i_wr && is_full && !rd_ok)) err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            wrptr_reg <= '0;
            rdptr_reg <= '0;
            fill_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            wrptr_reg <= wrptr_next;
            rdptr_reg <= rdptr_next;
            fill_reg  <= fill_next;
            err_reg   <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst && !i_clr && wr_ok) begin
            mem[wrptr_reg] <= i_data;
        end
    end

    assign o_data      = mem[rdptr_reg];
    assign o_empty_n   = !is_empty;
    assign o_full      = is_full;
    assign o_err       = err_reg;
    assign o_fill      = fill_reg;
    assign o_dmp_data  = mem[rdptr_reg + i_dmp_pos];
    assign o_dmp_valid = ({1'b0, i_dmp_pos} < fill_reg);

endmodule

// File: rtl/hrm_iobox.sv
// Bank of NCH independent FIFO channels with a registered, side-effect-free
// dump port that reads any live entry of a selected channel.
module hrm_iobox
    import hrm_pkg::*;
#(
    parameter int DW      = HRM_DW,
    parameter int LGDEPTH = HRM_LGDEPTH,
    parameter int NCH     = HRM_NCH,
    parameter int SW      = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic [NCH-1:0]           i_wr,
    input  logic [NCH*DW-1:0]        i_data,
    input  logic [NCH-1:0]           i_rd,
    input  logic [NCH-1:0]           i_clr,
    output logic [NCH*DW-1:0]        o_data,
    output logic [NCH-1:0]           o_empty_n,
    output logic [NCH-1:0]           o_full,
    output logic [NCH-1:0]           o_err,
    output logic [NCH*(LGDEPTH+1)-1:0] o_fill,
    input  logic [SW-1:0]            i_dmp_sel,
    input  logic [LGDEPTH-1:0]       i_dmp_pos,
    output logic [DW-1:0]            o_dmp_data,
    output logic                     o_dmp_valid
);

    logic [DW-1:0]  ch_dmp_data [NCH];
    logic [NCH-1:0] ch_dmp_valid;
    logic [DW-1:0]  dmp_data_reg, dmp_data_next;
    logic           dmp_valid_reg, dmp_valid_next;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            hrm_fifo_ch #(
                .DW      (DW),
                .LGDEPTH (LGDEPTH)
            ) u_ch (
                .clk         (clk),
                .i_rst       (i_rst),
                .i_wr        (i_wr[gi]),
                .i_data      (i_data[gi*DW +: DW]),
                .i_rd        (i_rd[gi]),
                .i_clr       (i_clr[gi]),
                .o_data      (o_data[gi*DW +: DW]),
                .o_empty_n   (o_empty_n[gi]),
                .o_full      (o_full[gi]),
                .o_err       (o_err[gi]),
                .o_fill      (o_fill[gi*(LGDEPTH+1) +: (LGDEPTH+1)]),
                .i_dmp_pos   (i_dmp_pos),
                .o_dmp_data  (ch_dmp_data[gi]),
                .o_dmp_valid (ch_dmp_valid[gi])
            );
        end
    endgenerate

    // A select that matches no channel leaves the dump invalid with zero data.
    always_comb begin
        dmp_data_next  = '0;
        dmp_valid_next = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (i_dmp_sel == SW'(k) && ch_dmp_valid[k]) begin
                dmp_valid_next = 1'b1;
                dmp_data_next  = ch_dmp_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            dmp_data_reg  <= '0;
            dmp_valid_reg <= 1'b0;
        end else begin
            dmp_data_reg  <= dmp_data_next;
            dmp_valid_reg <= dmp_valid_next;
        end
    end

    assign o_dmp_data  = dmp_data_reg;
    assign o_dmp_valid = dmp_valid_reg;

endmodule

// File: tb/tb_hrm_iobox.sv
// Self-checking bench for hrm_iobox: vector table, FIFO reference model and a
// dump scoreboard queue.
module tb_hrm_iobox;

    localparam int DW = 8;
    localparam int LG = 5;
    localparam int NCH = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    wr, rd, clr;
    logic [NCH*DW-1:0] din;
    logic [NCH*DW-1:0] dout;
    logic [NCH-1:0]    empty_n, full, err;
    logic [NCH*(LG+1)-1:0] fill;
    logic              dsel;
    logic [LG-1:0]     dpos;
    logic [DW-1:0]     ddata;
    logic              dvalid;

    hrm_iobox #(.DW(DW), .LGDEPTH(LG), .NCH(NCH)) dut (
        .clk         (clk),
        .i_rst       (rst_n),
        .i_wr        (wr),
        .i_data      (din),
        .i_rd        (rd),
        .i_clr       (clr),
        .o_data      (dout),
        .o_empty_n   (empty_n),
        .o_full      (full),
        .o_err       (err),
        .o_fill      (fill),
        .i_dmp_sel   (dsel),
        .i_dmp_pos   (dpos),
        .o_dmp_data  (ddata),
        .o_dmp_valid (dvalid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ncyc = 0;

    // reference model: shift-register FIFO per channel
    logic [7:0] mq [NCH][DEPTH];
    int         mcnt [NCH];
    logic       merr [NCH];

    typedef struct {
        logic       v;
        logic [7:0] d;
    } dmp_exp_t;
    dmp_exp_t sb [$];

    typedef struct {
        logic [1:0] w;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] r;
        logic [1:0] c;
        int         f0;
        int         f1;
        int         h0;
        logic [1:0] e;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            mcnt[k] = 0;
            merr[k] = 1'b0;
        end
    endtask

    task automatic cyc(input logic rst, input logic [1:0] w, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] r, input logic [1:0] c,
                       input logic sel, input logic [4:0] pos);
        dmp_exp_t de;
        dmp_exp_t got;
        logic [7:0] dk;
        logic popok, pushok;
        rst_n = rst; wr = w; rd = r; clr = c; din = {d1, d0}; dsel = sel; dpos = pos;
        de.v = 1'b0;
        de.d = 8'h00;
        if (rst && int'(pos) < mcnt[sel]) begin
            de.v = 1'b1;
            de.d = mq[sel][pos];
        end
        sb.push_back(de);
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NCH; k++) begin
                dk = (k == 0) ? d0 : d1;
                if (c[k]) begin
                    mcnt[k] = 0;
                    merr[k] = 1'b0;
                end else begin
                    popok  = r[k] && mcnt[k] > 0;
                    pushok = w[k] && (mcnt[k] < DEPTH || popok);
                    if (r[k] && mcnt[k] == 0) merr[k] = 1'b1;
                    if (w[k] && mcnt[k] == DEPTH && !popok) merr[k] = 1'b1;
                    if (popok) begin
                        for (int i = 0; i < DEPTH - 1; i++) mq[k][i] = mq[k][i+1];
                        mcnt[k]--;
                    end
                    if (pushok) begin
                        mq[k][mcnt[k]] = dk;
                        mcnt[k]++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
        got = sb.pop_front();
        chk("dmp_valid", int'(dvalid), int'(got.v));
        chk("dmp_data", int'(ddata), int'(got.d));
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("fill%0d", k), int'(fill[k*(LG+1) +: (LG+1)]), mcnt[k]);
            chk($sformatf("empty_n%0d", k), int'(empty_n[k]), int'(mcnt[k] != 0));
            chk($sformatf("full%0d", k), int'(full[k]), int'(mcnt[k] == DEPTH));
            chk($sformatf("err%0d", k), int'(err[k]), int'(merr[k]));
            if (mcnt[k] != 0) chk($sformatf("head%0d", k), int'(dout[k*DW +: DW]), int'(mq[k][0]));
        end
        $display("cyc %0d rst=%b wr=%b rd=%b clr=%b fill0=%0d fill1=%0d err=%b dmp=%b/%02h",
                 ncyc, rst, w, r, c, fill[0 +: 6], fill[6 +: 6], err, dvalid, ddata);
    endtask

    initial begin
        logic [7:0] exp_d;
        rst_n = 1'b0; wr = '0; rd = '0; clr = '0; din = '0; dsel = 1'b0; dpos = '0;
        for (int k = 0; k < NCH; k++) for (int i = 0; i < DEPTH; i++) mq[k][i] = 8'h00;
        model_reset();

        // reset state
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 5'd0);
        cyc(1'b0, 2'b11, 8'h12, 8'h34, 2'b11, 2'b00, 1'b1, 5'd0);
        chk("rst_empty_n", int'(empty_n), 0);
        chk("rst_full", int'(full), 0);

        // hand-derived vectors: basic order, pop-on-empty with push, clr vs push
        tbl[0]  = '{2'b01, 8'h11, 8'h00, 2'b00, 2'b00, 1, 0, 8'h11, 2'b00};
        tbl[1]  = '{2'b01, 8'h22, 8'h00, 2'b00, 2'b00, 2, 0, 8'h11, 2'b00};
        tbl[2]  = '{2'b01, 8'h33, 8'h00, 2'b00, 2'b00, 3, 0, 8'h11, 2'b00};
        tbl[3]  = '{2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2, 0, 8'h22, 2'b00};
        tbl[4]  = '{2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1, 0, 8'h33, 2'b00};
        tbl[5]  = '{2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 0, 0, -1,    2'b00};
        tbl[6]  = '{2'b01, 8'h5A, 8'h00, 2'b01, 2'b00, 1, 0, 8'h5A, 2'b01};
        tbl[7]  = '{2'b10, 8'h00, 8'hAA, 2'b00, 2'b00, 1, 1, 8'h5A, 2'b01};
        tbl[8]  = '{2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 1, 0, 8'h5A, 2'b01};
        tbl[9]  = '{2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 1, 0, 8'h5A, 2'b11};
        tbl[10] = '{2'b10, 8'h00, 8'hBB, 2'b00, 2'b10, 1, 0, 8'h5A, 2'b01};
        tbl[11] = '{2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 0, 0, -1,    2'b00};
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, tbl[i].w, tbl[i].d0, tbl[i].d1, tbl[i].r, tbl[i].c, 1'b0, 5'd0);
            chk($sformatf("tbl%0d_fill0", i), int'(fill[0 +: 6]), tbl[i].f0);
            chk($sformatf("tbl%0d_fill1", i), int'(fill[6 +: 6]), tbl[i].f1);
            chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e));
            if (tbl[i].h0 >= 0) chk($sformatf("tbl%0d_head0", i), int'(dout[0 +: 8]), tbl[i].h0);
        end

        // fill ch1, overflow, then push+pop while full
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 2'b10, 8'h00, 8'(8'h80 + i), 2'b00, 2'b00, 1'b1, 5'(i));
        chk("ch1_full", int'(full[1]), 1);
        chk("ch1_err_pre", int'(err[1]), 0);
        cyc(1'b1, 2'b10, 8'h00, 8'hEE, 2'b00, 2'b00, 1'b1, 5'd31);
        chk("ch1_ovf_err", int'(err[1]), 1);
        chk("ch1_ovf_fill", int'(fill[6 +: 6]), 32);
        cyc(1'b1, 2'b10, 8'h00, 8'hF0, 2'b10, 2'b00, 1'b1, 5'd31);
        chk("ch1_pp_fill", int'(fill[6 +: 6]), 32);
        chk("ch1_pp_head", int'(dout[8 +: 8]), 8'h81);
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 5'd31);
        chk("ch1_tail", int'(ddata), 8'hF0);

        // pointer wrap on ch0 then dump every position
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b11, 1'b0, 5'd0);
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 2'b01, 8'(8'h40 + i), 8'h00, 2'b00, 2'b00, 1'b0, 5'd0);
        for (int i = 0; i < 30; i++)
            cyc(1'b1, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 2'b01, 8'(8'hC0 + i), 8'h00, 2'b00, 2'b00, 1'b0, 5'd0);
        for (int p = 0; p < 8; p++) begin
            cyc(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 5'(p));
            exp_d = (p < 2) ? 8'(8'h5E + p) : (p < 7) ? 8'(8'hC0 + p - 2) : 8'h00;
            chk($sformatf("wrap_dv%0d", p), int'(dvalid), int'(p < 7));
            chk($sformatf("wrap_dd%0d", p), int'(ddata), int'(exp_d));
        end

        // reset mid-stream with pushes and dump active
        cyc(1'b1, 2'b10, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0, 5'd0);
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0, 5'd1);
        chk("pre_rst_err1", int'(err[1]), 1);
        cyc(1'b0, 2'b11, 8'h99, 8'h98, 2'b00, 2'b00, 1'b0, 5'd0);
        chk("mid_rst_fill", int'(fill), 0);
        chk("mid_rst_flags", int'({empty_n, full, err}), 0);
        chk("mid_rst_dmp", int'({dvalid, ddata}), 0);
        cyc(1'b1, 2'b11, 8'h71, 8'h72, 2'b00, 2'b00, 1'b1, 5'd0);
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 5'd0);
        chk("post_rst_dmp", int'(ddata), 8'h72);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hrm_iobox.md
HRM_IOBOX -- requirements
Module: hrm_iobox

Interface
REQ-001 Parameter DW, default 8: data width of every channel, in bits.
REQ-002 Parameter LGDEPTH, default 5: log2 of the depth of each channel (DEPTH = 2^LGDEPTH entries).
REQ-003 Parameter NCH, default 2: number of independent FIFO channels (ch0 = INBOX, ch1 = OUTBOX in the CPU).
REQ-004 Parameter SW = max(1, clog2(NCH)): width of the dump channel select.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 i_rst  input  1  synchronous, active-low reset.
REQ-007 i_wr  input  NCH  per-channel push strobe.
REQ-008 i_data  input  NCH*DW  per-channel push data; channel k occupies bits [k*DW +: DW].
REQ-009 i_rd  input  NCH  per-channel pop strobe.
REQ-010 i_clr  input  NCH  per-channel flush; clears the channel's contents and its error flag.
REQ-011 o_data  output  NCH*DW  per-channel head entry, first-word-fall-through.
REQ-012 o_empty_n  output  NCH  channel holds at least one entry.
REQ-013 o_full  output  NCH  channel holds DEPTH entries.
REQ-014 o_err  output  NCH  sticky flag: overflow or underflow has occurred.
REQ-015 o_fill  output  NCH*(LGDEPTH+1)  per-channel occupancy count.
REQ-016 i_dmp_sel  input  SW  channel selected for dump.
REQ-017 i_dmp_pos  input  LGDEPTH  dump position; 0 = oldest entry.
REQ-018 o_dmp_data  output  DW  entry at the dumped position.
REQ-019 o_dmp_valid  output  1  dumped position lies within the selected channel's occupancy.

Function
REQ-020 Each channel SHALL be a circular buffer with a LGDEPTH-bit write pointer, a LGDEPTH-bit read pointer and a (LGDEPTH+1)-bit fill counter; both pointers wrap modulo DEPTH.
REQ-021 Push: when i_wr[k] is high and the channel is not full, or i_rd[k] is also accepted in the same cycle, the channel SHALL store the data at the write pointer and increment the write pointer.
REQ-022 Push to a full channel without a simultaneous pop: the data SHALL be dropped and o_err[k] set; contents are unchanged.
REQ-023 Pop: when i_rd[k] is high and o_empty_n[k] is high, the channel SHALL increment the read pointer.
REQ-024 Pop from an empty channel: the pop SHALL be ignored and o_err[k] set; a same-cycle push SHALL still be accepted.
REQ-025 Simultaneous accepted push and pop: the fill count SHALL be unchanged; on a full channel both operations occur.
REQ-026 o_data[k] SHALL equal the memory entry at the read pointer, with no read latency; its value is don't-care while the channel is empty.
REQ-027 Status: o_empty_n = (fill != 0), o_full = (fill == DEPTH), o_fill = fill; all derived from registered state and updated the cycle after the event.
REQ-028 i_clr[k] SHALL zero both pointers, fill[k] and o_err[k], and SHALL take priority over a same-cycle push or pop on that channel; other channels are unaffected.
REQ-029 o_err[k] SHALL remain set until reset or i_clr[k].
REQ-030 Dump: registered with 1-cycle latency; it samples the pre-update state of the request cycle.
REQ-031 o_dmp_valid SHALL equal (i_dmp_sel < NCH) && (i_dmp_pos < fill[sel]).
REQ-032 o_dmp_data SHALL be the entry at (rdptr[sel] + i_dmp_pos) mod DEPTH when valid, and 0 otherwise.
REQ-033 The dump path SHALL have no side effect on FIFO state.

Reset
REQ-034 While i_rst is low at a clock edge, every channel SHALL return to pointers = 0, fill = 0 and o_err = 0.
REQ-035 Reset SHALL force o_dmp_data = 0 and o_dmp_valid = 0.
REQ-036 After reset, o_empty_n = 0 and o_full = 0 on all channels.
REQ-037 Memory contents are not reset.
REQ-038 Reset SHALL override push, pop, clr and dump requests issued in the same cycle, including reset asserted mid-stream.

Structure
REQ-039 Package hrm_pkg SHALL hold the clog2 function and the default DW/LGDEPTH/NCH constants.
REQ-040 One sub-module, hrm_fifo_ch (single channel with a dump-read port), SHALL be instantiated NCH times via generate.
REQ-041 The top level SHALL contain only the dump mux and its output register.

Verification
REQ-042 Push 0x11, 0x22, 0x33 on ch0 -> o_fill[ch0] = 3, o_data[ch0] = 0x11; pop once -> o_data[ch0] = 0x22, fill = 2.
REQ-043 Push 32 values on ch1 -> o_full[1] = 1; a 33rd push -> dropped and o_err[1] = 1; push plus pop while full -> fill stays 32 and the new value enters at the tail.
REQ-044 Pop on empty ch0 while pushing 0x5A in the same cycle -> o_err[0] = 1, fill = 1, o_data[0] = 0x5A.
REQ-045 Fill ch0, pop 30, push 5 (pointer wrap) -> dump sel = 0, pos = 0..6 returns the FIFO order with valid = 1; pos = 7 returns valid = 0, data = 0.
REQ-046 i_clr[1] asserted together with push on ch1 -> ch1 empty with o_err[1] = 0; ch0 unchanged.
REQ-047 Assert i_rst low mid-stream with pushes active -> all fills 0, flags 0, dump outputs 0 on the next cycle.
